// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned STATE_W = 2;

  // State encoding is also what state_o reports; 2'b11 is the spare code.
  typedef enum logic [STATE_W-1:0] {
    ST_FILL = 2'b00,
    ST_HUNT = 2'b01,
    ST_LOAD = 2'b10
  } state_e;

  localparam logic [3:0] DEFAULT_PAT = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky flag raised on the increment that reaches all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX_CNT = '1;

  // A clear coinciding with an increment counts that event on top of the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
      sat   <= 1'b0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + W'(1);
      if (count == (MAX_CNT - W'(1))) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable PAT_LEN-bit pattern,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned            PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0]     RESET_PAT = PAT_LEN'(DEFAULT_PAT),
  parameter int unsigned            CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr_count,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned         FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_LEN);

  state_e             r_state;
  logic [PAT_LEN-1:0] r_hist;
  logic [PAT_LEN-1:0] r_pat;
  logic [FILL_W-1:0]  r_fill;
  logic               r_out;

  logic               w_bit_ok;
  logic               w_armed;
  logic [PAT_LEN-1:0] w_window;
  logic               w_match;

  // A bit is usable unless a load is happening in the same cycle.
  assign w_bit_ok = in_valid && !pat_load;
  // The completing bit may arrive while still filling, as long as it is the PAT_LEN-th one.
  assign w_armed  = (r_state == ST_HUNT) ||
                    ((r_state == ST_FILL) && (r_fill == FILL_LAST));
  assign w_window = {r_hist[PAT_LEN-2:0], in};
  assign w_match  = w_bit_ok && w_armed && (w_window == r_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_hist  <= '0;
      r_pat   <= RESET_PAT;
      r_fill  <= '0;
      r_out   <= 1'b0;
    end else begin
      r_out <= w_match;
      if (pat_load) begin
        r_pat   <= pat_in;
        r_hist  <= '0;
        r_fill  <= '0;
        r_state <= ST_LOAD;
      end else if (in_valid) begin
        if (w_match && !overlap) begin
          r_hist  <= '0;
          r_fill  <= '0;
          r_state <= ST_FILL;
        end else begin
          r_hist <= w_window;
          if (r_state != ST_HUNT) begin
            if (r_fill == FILL_LAST) begin
              r_fill  <= FILL_FULL;
              r_state <= ST_HUNT;
            end else begin
              r_fill  <= r_fill + FILL_W'(1);
              r_state <= ST_FILL;
            end
          end
        end
      end else if ((r_state != ST_HUNT) && (r_state != ST_FILL)) begin
        // LOAD (or the spare code) always falls back to FILL after one cycle.
        r_state <= ST_FILL;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (clr_count),
    .count (match_count),
    .sat   (count_sat)
  );

  assign out     = r_out;
  assign state_o = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (default build plus a CNT_W=2 / 1111 build).
module tb_seq_detector_param;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       t_reset;
  logic       t_in;
  logic       t_in_valid;
  logic       t_overlap;
  logic       t_pat_load;
  logic [3:0] t_pat_in;
  logic       t_clr;

  logic       a_out;
  logic [7:0] a_cnt;
  logic       a_sat;
  logic [1:0] a_state;

  logic       b_out;
  logic [1:0] b_cnt;
  logic       b_sat;
  logic [1:0] b_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk         (clk),
    .reset       (t_reset),
    .in          (t_in),
    .in_valid    (t_in_valid),
    .overlap     (t_overlap),
    .pat_load    (t_pat_load),
    .pat_in      (t_pat_in),
    .clr_count   (t_clr),
    .out         (a_out),
    .match_count (a_cnt),
    .count_sat   (a_sat),
    .state_o     (a_state)
  );

  seq_detector_param #(
    .PAT_LEN   (4),
    .RESET_PAT (4'b1111),
    .CNT_W     (2)
  ) u_dut_sat (
    .clk         (clk),
    .reset       (t_reset),
    .in          (t_in),
    .in_valid    (t_in_valid),
    .overlap     (t_overlap),
    .pat_load    (t_pat_load),
    .pat_in      (t_pat_in),
    .clr_count   (t_clr),
    .out         (b_out),
    .match_count (b_cnt),
    .count_sat   (b_sat),
    .state_o     (b_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Present one cycle of input, then sample just after the rising edge.
  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    t_in_valid = v;
    t_in       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    t_reset    = 1'b1;
    t_in_valid = 1'b0;
    t_in       = 1'b0;
    t_pat_load = 1'b0;
    t_clr      = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    t_reset = 1'b0;
  endtask

  // Bits and expected pulses are given MSB-first; a trailing idle cycle must show out=0.
  task automatic run_stream(input string tag, input logic [31:0] bits,
                            input logic [31:0] pulses, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, bits[i]);
      chk($sformatf("%s_bit%0d", tag, n - i), 32'(a_out), 32'(pulses[i]));
    end
    drive(1'b0, 1'b0);
    chk($sformatf("%s_tail", tag), 32'(a_out), 32'd0);
  endtask

  initial begin
    int exp_c [7] = '{0, 0, 0, 1, 2, 3, 3};
    int exp_s [7] = '{0, 0, 0, 0, 0, 1, 1};
    int exp_o [7] = '{0, 0, 0, 1, 1, 1, 1};

    t_reset = 1'b1; t_in = 1'b0; t_in_valid = 1'b0; t_overlap = 1'b1;
    t_pat_load = 1'b0; t_pat_in = 4'b0000; t_clr = 1'b0;
    do_reset();
    chk("rst_out",   32'(a_out),   32'd0);
    chk("rst_cnt",   32'(a_cnt),   32'd0);
    chk("rst_sat",   32'(a_sat),   32'd0);
    chk("rst_state", 32'(a_state), 32'(ST_FILL));
    chk("rst_cnt_b", 32'(b_cnt),   32'd0);

    // Overlapping detection on the default pattern.
    t_overlap = 1'b1;
    run_stream("ovl", 32'b1011011, 32'b0001001, 7);
    chk("ovl_cnt", 32'(a_cnt), 32'd2);
    chk("ovl_state", 32'(a_state), 32'(ST_HUNT));

    // Non-overlapping: the shared tail cannot be reused.
    do_reset();
    t_overlap = 1'b0;
    run_stream("novl", 32'b1011011, 32'b0001000, 7);
    chk("novl_cnt", 32'(a_cnt), 32'd1);
    do_reset();
    run_stream("novl2", 32'b10111011, 32'b00010001, 8);
    chk("novl2_cnt", 32'(a_cnt), 32'd2);

    // Pattern load with a valid bit in the same cycle.
    do_reset();
    t_overlap = 1'b1;
    @(negedge clk);
    t_pat_load = 1'b1; t_pat_in = 4'b0110; t_in_valid = 1'b1; t_in = 1'b0;
    @(posedge clk); #1;
    chk("load_state", 32'(a_state), 32'(ST_LOAD));
    chk("load_out",   32'(a_out),   32'd0);
    @(negedge clk);
    t_pat_load = 1'b0; t_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("load_to_fill", 32'(a_state), 32'(ST_FILL));
    run_stream("pat0110", 32'b0110110, 32'b0001001, 7);
    run_stream("old1011", 32'b1011, 32'b0000, 4);
    chk("pat0110_cnt", 32'(a_cnt), 32'd2);

    // Gaps in in_valid hold everything.
    do_reset();
    t_overlap = 1'b1;
    drive(1'b1, 1'b1); chk("gap_b1", 32'(a_out), 32'd0);
    drive(1'b1, 1'b0); chk("gap_b2", 32'(a_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      chk($sformatf("gap_idle%0d", i), 32'(a_out), 32'd0);
      chk($sformatf("gap_state%0d", i), 32'(a_state), 32'(ST_FILL));
    end
    drive(1'b1, 1'b1); chk("gap_b3", 32'(a_out), 32'd0);
    drive(1'b1, 1'b1); chk("gap_b4", 32'(a_out), 32'd1);
    drive(1'b0, 1'b0); chk("gap_tail", 32'(a_out), 32'd0);
    chk("gap_cnt", 32'(a_cnt), 32'd1);

    // Reset mid-stream discards partial history and the count.
    run_stream("pre_rst", 32'b101, 32'b000, 3);
    do_reset();
    chk("mid_rst_cnt",   32'(a_cnt),   32'd0);
    chk("mid_rst_state", 32'(a_state), 32'(ST_FILL));
    drive(1'b1, 1'b1);
    chk("mid_rst_out",   32'(a_out),   32'd0);
    chk("mid_rst_fill",  32'(a_state), 32'(ST_FILL));
    drive(1'b0, 1'b0);
    chk("mid_rst_tail",  32'(a_out),   32'd0);

    // Saturation on the 2-bit counter build with pattern 1111.
    do_reset();
    t_overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1);
      chk($sformatf("sat_out%0d", i), 32'(b_out), 32'(exp_o[i]));
      chk($sformatf("sat_cnt%0d", i), 32'(b_cnt), 32'(exp_c[i]));
      chk($sformatf("sat_flag%0d", i), 32'(b_sat), 32'(exp_s[i]));
    end
    @(negedge clk);
    t_clr = 1'b1; t_in_valid = 1'b1; t_in = 1'b1;
    @(posedge clk); #1;
    chk("clr_match_out", 32'(b_out), 32'd1);
    chk("clr_match_cnt", 32'(b_cnt), 32'd1);
    chk("clr_match_sat", 32'(b_sat), 32'd0);
    @(negedge clk);
    t_clr = 1'b0; t_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_hold_cnt", 32'(b_cnt), 32'd1);
    chk("clr_hold_out", 32'(b_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
